// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op/state encodings and schedule constants for the RV32M sequencer
package mdu_pkg;

   typedef enum logic [2:0] {
      OP_MUL    = 3'd0,
      OP_MULH   = 3'd1,
      OP_MULHSU = 3'd2,
      OP_MULHU  = 3'd3,
      OP_DIV    = 3'd4,
      OP_DIVU   = 3'd5,
      OP_REM    = 3'd6,
      OP_REMU   = 3'd7
   } mdu_op_e;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_PREP_A = 3'd1,
      S_PREP_B = 3'd2,
      S_ITER   = 3'd3,
      S_FIX_LO = 3'd4,
      S_FIX_HI = 3'd5,
      S_DONE   = 3'd6
   } mdu_state_e;

   localparam int MDU_ITER    = 32;
   localparam int MDU_LATENCY = 37;

   function automatic logic rs1_signed(input mdu_op_e op);
      return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
   endfunction

   function automatic logic rs2_signed(input mdu_op_e op);
      return op inside {OP_MULH, OP_DIV, OP_REM};
   endfunction

endpackage

// File: rtl/FA_32bit.sv
// FA_32bit: the one shared 32-bit adder (sum = a + b + cin, with carry out)
module FA_32bit (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cin,
   output logic [31:0] sum,
   output logic        cout
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {32'b0, cin};

endmodule

// File: rtl/mdu_seq.sv
// mdu_seq: iterative RV32M multiply/divide over one shared adder; divide path present only with MDU_DIV_EN
module mdu_seq
   import mdu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_start,
   input  logic [2:0]      i_op,
   input  logic [XLEN-1:0] i_rs1,
   input  logic [XLEN-1:0] i_rs2,
   output logic            o_busy,
   output logic            o_done,
   output logic [XLEN-1:0] o_result
);

   mdu_state_e      state, state_n;
   mdu_op_e         op;
   logic [XLEN-1:0] a, b, acc, lo, result;
   logic [4:0]      cnt;
   logic            neg, carry;
   logic [XLEN-1:0] fa_a, fa_b, sum;
   logic            fa_cin, cout;
   logic [XLEN:0]   mul_t;
   logic [XLEN-1:0] b_mag, short_res;
   logic            short_op, s1, s2, lo_sel;
`ifdef MDU_DIV_EN
   logic            take;
`endif

   FA_32bit u_fa (.a(fa_a), .b(fa_b), .cin(fa_cin), .sum(sum), .cout(cout));

   assign s1     = rs1_signed(mdu_op_e'(i_op)) & i_rs1[XLEN-1];
   assign s2     = rs2_signed(mdu_op_e'(i_op)) & i_rs2[XLEN-1];
   assign b_mag  = (rs2_signed(op) && b[XLEN-1]) ? sum : b;
   assign mul_t  = lo[0] ? {cout, sum} : {1'b0, acc};
   assign lo_sel = (op == OP_MUL) || (op[2] && !op[1]);
`ifdef MDU_DIV_EN
   // a divide with a zero divisor skips the schedule entirely
   assign take      = acc[XLEN-1] | cout;
   assign short_op  = i_op[2] && (i_rs2 == '0);
   assign short_res = i_op[1] ? i_rs1 : '1;
`else
   // without the divide datapath every divide op answers zero at once
   assign short_op  = i_op[2];
   assign short_res = '0;
`endif

   // state register
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) state <= S_IDLE;
      else          state <= state_n;

   // fixed schedule: two prep cycles, 32 iterations, two fix-up cycles
   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:   if (i_start) state_n = short_op ? S_DONE : S_PREP_A;
         S_PREP_A: state_n = S_PREP_B;
         S_PREP_B: state_n = S_ITER;
         S_ITER:   if (cnt == 5'(MDU_ITER - 1)) state_n = S_FIX_LO;
         S_FIX_LO: state_n = S_FIX_HI;
         S_FIX_HI: state_n = S_DONE;
         default:  state_n = S_IDLE;
      endcase
   end

   // handshake outputs decoded from state; result is a register
   always_comb begin
      o_busy   = state != S_IDLE;
      o_done   = state == S_DONE;
      o_result = result;
   end

   // state-indexed operand mux for the single adder
   always_comb begin
      fa_a   = '0;
      fa_b   = '0;
      fa_cin = 1'b0;
      case (state)
         S_PREP_A: begin fa_a = ~a; fa_cin = 1'b1; end
         S_PREP_B: begin fa_a = ~b; fa_cin = 1'b1; end
         S_ITER: begin
`ifdef MDU_DIV_EN
            if (op[2]) begin fa_a = {acc[XLEN-2:0], lo[XLEN-1]}; fa_b = ~b; fa_cin = 1'b1; end else
`endif
            begin fa_a = acc; fa_b = a; end
         end
         S_FIX_LO: begin fa_a = ~lo; fa_cin = 1'b1; end
         S_FIX_HI: begin fa_a = ~acc; fa_cin = op[2] | carry; end
         default: ;
      endcase
   end

   // datapath: magnitudes, shift-add / restoring divide, sign fix-up, result capture
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         op     <= OP_MUL;
         a      <= '0;
         b      <= '0;
         acc    <= '0;
         lo     <= '0;
         cnt    <= '0;
         neg    <= 1'b0;
         carry  <= 1'b0;
         result <= '0;
      end else begin
         case (state)
            S_IDLE: if (i_start) begin
               op  <= mdu_op_e'(i_op);
               a   <= i_rs1;
               b   <= i_rs2;
               acc <= '0;
               lo  <= '0;
               cnt <= '0;
               neg <= (mdu_op_e'(i_op) == OP_REM) ? s1 : s1 ^ s2;
               if (short_op) result <= short_res;
            end
            S_PREP_A: if (rs1_signed(op) && a[XLEN-1]) a <= sum;
            S_PREP_B: begin
               b  <= b_mag;
               lo <= op[2] ? a : b_mag;
            end
            S_ITER: begin
               cnt <= cnt + 5'd1;
`ifdef MDU_DIV_EN
               if (op[2]) begin
                  acc <= take ? sum : {acc[XLEN-2:0], lo[XLEN-1]};
                  lo  <= {lo[XLEN-2:0], take};
               end else
`endif
               begin
                  acc <= mul_t[XLEN:1];
                  lo  <= {mul_t[0], lo[XLEN-1:1]};
               end
            end
            S_FIX_LO: begin
               if (neg) lo <= sum;
               carry <= cout;
            end
            S_FIX_HI: result <= lo_sel ? lo : (neg ? sum : acc);
            default: ;
         endcase
      end

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: scoreboard bench for mdu_seq against an arithmetic reference model
module tb_mdu_seq;

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        i_start = 1'b0;
   logic [2:0]  i_op = 3'd0;
   logic [31:0] i_rs1 = '0;
   logic [31:0] i_rs2 = '0;
   logic        o_busy, o_done;
   logic [31:0] o_result;

   typedef struct {
      logic [31:0] res;
      int          lat;
      int          t0;
      int          op;
   } exp_t;

   exp_t q[$];
   int   nvec = 0;
   int   nbad = 0;
   int   cyc = 0;
   int   busy_cnt = 0;

   mdu_seq dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_op(i_op),
      .i_rs1(i_rs1), .i_rs2(i_rs2), .o_busy(o_busy), .o_done(o_done), .o_result(o_result)
   );

   always #5 i_clk = ~i_clk;

   always @(posedge i_clk) cyc <= cyc + 1;

   function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb, ua, ub;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'h0, a});
      ub = longint'({32'h0, b});
      p  = '0;
      case (op)
         3'd0: begin p = ua * ub; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         default: ;
      endcase
`ifdef MDU_DIV_EN
      if (b == 32'h0) return op[1] ? a : 32'hFFFFFFFF;
      case (op)
         3'd4:    p = sa / sb;
         3'd5:    p = ua / ub;
         3'd6:    p = sa % sb;
         default: p = ua % ub;
      endcase
      return p[31:0];
`else
      return 32'h0;
`endif
   endfunction

   function automatic int latency(input logic [2:0] op, input logic [31:0] b);
`ifdef MDU_DIV_EN
      return (op[2] && b == 32'h0) ? 1 : 37;
`else
      return op[2] ? 1 : 37;
`endif
   endfunction

   task automatic chk(input string name, input int op, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nbad++;
         $display("FAIL %s op=%0d got=%h want=%h", name, op, act, exp);
      end
   endtask

   // monitor: count busy cycles and score every done pulse against the queue
   always @(negedge i_clk) begin
      exp_t e;
      if (!o_busy) busy_cnt = 0;
      else busy_cnt++;
      if (o_done) begin
         if (q.size() == 0) begin
            nvec++;
            nbad++;
            $display("FAIL unexpected_done got=%h want=no_done", o_result);
         end else begin
            e = q.pop_front();
            chk("result", e.op, o_result, e.res);
            chk("latency", e.op, 32'(cyc - e.t0), 32'(e.lat));
            chk("busy_cycles", e.op, 32'(busy_cnt), 32'(e.lat));
         end
      end
   end

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      int   n = 0;
      while (o_busy && n < 200) begin
         @(negedge i_clk);
         n++;
      end
      if (o_busy) begin
         nvec++;
         nbad++;
         $display("FAIL idle_timeout op=%0d got=busy want=idle", op);
      end
      e.res = model(op, a, b);
      e.lat = latency(op, b);
      e.t0  = cyc;
      e.op  = int'(op);
      q.push_back(e);
      i_start = 1'b1;
      i_op    = op;
      i_rs1   = a;
      i_rs2   = b;
      @(negedge i_clk);
      i_start = 1'b0;
   endtask

   initial begin
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      int          n;
      #1;
      chk("reset_busy", 0, {31'b0, o_busy}, 32'h0);
      chk("reset_done", 0, {31'b0, o_done}, 32'h0);
      chk("reset_result", 0, o_result, 32'h0);
      repeat (2) @(negedge i_clk);
      i_rst_n = 1'b1;
      @(negedge i_clk);

      issue(3'd0, 32'd7, 32'hFFFFFFFD);
      issue(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);
      issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
      issue(3'd2, 32'hFFFFFFFF, 32'd2);
      issue(3'd4, 32'hFFFFFFF9, 32'd2);
      issue(3'd6, 32'hFFFFFFF9, 32'd2);
      issue(3'd5, 32'd100, 32'd7);
      issue(3'd7, 32'd100, 32'd7);
      issue(3'd5, 32'd5, 32'd0);
      issue(3'd6, 32'd5, 32'd0);
      issue(3'd4, 32'h80000000, 32'hFFFFFFFF);
      issue(3'd6, 32'h80000000, 32'hFFFFFFFF);
      issue(3'd0, 32'd6, 32'd7);

      // a second start while busy must be ignored
      issue(3'd0, 32'h12345, 32'h321);
      repeat (8) @(negedge i_clk);
      i_start = 1'b1;
      i_op    = 3'd3;
      i_rs1   = 32'hDEADBEEF;
      i_rs2   = 32'hCAFEF00D;
      @(negedge i_clk);
      i_start = 1'b0;

      // reset mid-operation discards the op and clears outputs at once
      issue(3'd1, 32'h87654321, 32'h13579BDF);
      repeat (18) @(negedge i_clk);
      #2 i_rst_n = 1'b0;
      #1;
      chk("async_rst_busy", 1, {31'b0, o_busy}, 32'h0);
      chk("async_rst_result", 1, o_result, 32'h0);
      void'(q.pop_back());
      @(negedge i_clk);
      i_rst_n = 1'b1;
      @(negedge i_clk);
      issue(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);

      for (int k = 0; k < 150; k++) begin
         rop = 3'($urandom_range(0, 7));
         ra  = ($urandom_range(0, 9) == 0) ? 32'h80000000 : $urandom;
         case ($urandom_range(0, 9))
            0:       rb = 32'h0;
            1:       rb = 32'hFFFFFFFF;
            2:       rb = 32'($urandom_range(1, 15));
            default: rb = $urandom;
         endcase
         issue(rop, ra, rb);
      end

      n = 0;
      while (q.size() != 0 && n < 200) begin
         @(negedge i_clk);
         n++;
      end
      if (q.size() != 0) begin
         nvec++;
         nbad++;
         $display("FAIL drain_timeout got=%0d pending want=0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule

// File: doc/mdu_seq.md
# mdu_seq

Iterative RV32M multiply/divide sequencer that performs all M-extension arithmetic by time-multiplexing a single 32-bit ripple adder over a fixed-length schedule. It sits beside the ALU in the execute stage. The core holds the instruction with `o_busy` until `o_done` pulses. It trades latency for area: one add or subtract per cycle, with no dedicated multiplier array.

## Interface
- `XLEN`, 32: operand/result width; only 32 is supported.
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst_n`  in  1  reset, asynchronous and active-low.
- `i_start`  in  1  request; sampled only in IDLE.
- `i_op`  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `i_rs1`  in  32  multiplicand/dividend; captured with `i_start`.
- `i_rs2`  in  32  multiplier/divisor; captured with `i_start`.
- `o_busy`  out  1  high in every state except IDLE.
- `o_done`  out  1  one-cycle pulse; `o_result` is valid in that cycle.
- `o_result`  out  32  result; held after DONE until the next accepted start.

## Operation
- **States:** IDLE → PREP_A → PREP_B → ITER (32 cycles, counter 0..31) → FIX_LO → FIX_HI → DONE → IDLE.
- **Reset:** state IDLE; all registers 0; `o_busy`=0, `o_done`=0, `o_result`=0.
- **IDLE:** `i_start`=1 captures the op and operands and moves to PREP_A. Any `i_start` outside IDLE is ignored.
- **Single adder:** all arithmetic uses one adder instance with operands A, B, Cin. Subtraction is A + ~B + 1. Negation is ~X + 0 + 1.
- **PREP_A / PREP_B:** replace rs1 / rs2 with their magnitude when the op treats that operand as signed and its bit 31 is set.
  - rs1 is signed for MULH, MULHSU, DIV, REM.
  - rs2 is signed for MULH, DIV, REM.
  - Each state takes its cycle even when no negation is needed.
  - Result sign: rs1 sign XOR rs2 sign for MUL/MULH/MULHSU/DIV; rs1 sign for REM.
- **ITER, multiply (shift-add):**
  - 33-bit high accumulator plus a 32-bit low/multiplier register.
  - If multiplier LSB = 1, add the multiplicand to the accumulator; the adder Cout becomes accumulator bit 32.
  - Then shift {acc, lo} right by one.
- **ITER, divide (restoring):**
  - Shift {rem, quotient} left by one.
  - Trial = rem − divisor. Commit the trial and set quotient LSB when (shifted-out rem bit | Cout) = 1; otherwise keep rem and clear quotient LSB.
- **FIX_LO / FIX_HI:** when the result sign is negative, perform the two's-complement negation of the 64-bit product or of the quotient/remainder. FIX_LO produces the low word and a carry; FIX_HI consumes that carry. Both cycles are always spent.
- **DONE:** `o_done`=1. `o_result` is:
  - MUL: product[31:0].
  - MULH/MULHSU/MULHU: product[63:32].
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
- **Divide by zero:** on start with rs2=0 and a divide op, go IDLE → DONE directly. `o_result` = 0xFFFFFFFF for DIV/DIVU, rs1 for REM/REMU.
- **Signed overflow:** DIV 0x80000000 / 0xFFFFFFFF yields 0x80000000; REM yields 0. This falls out of the normal path with no special case.
- **Asynchronous reset mid-operation:** immediate return to IDLE with reset values; the partial result is discarded.

## Timing
- Start accepted in cycle 0.
- Normal ops: PREP_A in cycle 1, PREP_B in 2, ITER in 3–34, FIX_LO in 35, FIX_HI in 36, `o_done` in 37. Fixed 37-cycle latency independent of operand values.
- Divide by zero: `o_done` in cycle 1.
- `o_busy` is high from cycle 1 through the `o_done` cycle inclusive. A new start is accepted in the first IDLE cycle after `o_done`.
- `o_result` updates only on the edge entering DONE; it is registered with no combinational path from the inputs.

## Configuration
- `MDU_DIV_EN` defined: full behaviour as above.
- `MDU_DIV_EN` undefined: divide datapath and divide-by-zero detection are compiled out.
  - Ops 4–7 go IDLE → DONE with `o_result`=0 and `o_done` in cycle 1.
  - Multiply ops are unchanged.

## Structure
- Package `mdu_pkg` holds:
  - the `mdu_op_e` enum (8 ops, 3 bits);
  - the `mdu_state_e` enum;
  - `MDU_ITER` = 32;
  - `MDU_LATENCY` = 37.
- One sub-module: a single `FA_32bit` instance. Its A/B/Cin are driven by a state-indexed mux. No second adder is permitted.

## Test plan
- MUL rs1=7, rs2=0xFFFFFFFD → `o_result`=0xFFFFFFEB; `o_done` exactly 37 cycles after start; `o_busy` high cycles 1–37.
- MULHU rs1=rs2=0xFFFFFFFF → 0xFFFFFFFE; MULH with the same operands → 0x00000000; MULHSU rs1=0xFFFFFFFF, rs2=2 → 0xFFFFFFFF.
- DIV rs1=0xFFFFFFF9 (−7), rs2=2 → 0xFFFFFFFD; REM with the same operands → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIVU 5/0 → 0xFFFFFFFF with `o_done` in cycle 1; REM 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM → 0.
- Start MUL; pulse `i_start` again with different operands at cycle 10 → ignored and the first result is returned. Then assert `i_rst_n`=0 at cycle 20 of a new op → `o_busy`=0 and `o_result`=0 immediately; the next start completes normally.
- With `MDU_DIV_EN` undefined: DIV 100/7 → `o_result`=0 with `o_done` in cycle 1; MUL 6×7 → 42 in cycle 37.
